// File: rtl/lsu_pkg.sv
// Shared LSU definitions: I/O region bases, store-size and region encodings, and the
// address decoder used by both the store buffer and the load mux.
package lsu_pkg;

  localparam logic [11:0] BASE_LEDR = 12'h700;
  localparam logic [11:0] BASE_LEDG = 12'h701;
  localparam logic [11:0] BASE_HEX  = 12'h702;
  localparam logic [11:0] BASE_LCD  = 12'h703;
  localparam logic [11:0] BASE_SW   = 12'h780;

  typedef enum logic [1:0] {
    ST_BYTE  = 2'b00,
    ST_HALF  = 2'b01,
    ST_WORD  = 2'b10,
    ST_WORD3 = 2'b11
  } st_size_e;

  typedef enum logic [2:0] {
    RG_MEM,
    RG_LEDR,
    RG_LEDG,
    RG_HEX,
    RG_LCD,
    RG_SW
  } region_e;

  function automatic region_e decode_region(input logic [11:0] page);
    case (page)
      BASE_LEDR: decode_region = RG_LEDR;
      BASE_LEDG: decode_region = RG_LEDG;
      BASE_HEX:  decode_region = RG_HEX;
      BASE_LCD:  decode_region = RG_LCD;
      BASE_SW:   decode_region = RG_SW;
      default:   decode_region = RG_MEM;
    endcase
  endfunction

endpackage

// File: rtl/lsu_st_align.sv
// Store alignment: turns size and low address bits into a byte mask, lane-replicated
// data and a misalignment flag.
module lsu_st_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_bmask,
  output logic [31:0] o_wdata,
  output logic        o_misaligned
);

  always_comb begin
    o_bmask      = 4'b0000;
    o_wdata      = i_st_data;
    o_misaligned = 1'b0;
    case (st_size_e'(i_st_size))
      ST_BYTE: begin
        o_bmask = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_st_data[7:0]}};
      end
      ST_HALF: begin
        o_wdata = {2{i_st_data[15:0]}};
        if (i_addr_lo[0]) o_misaligned = 1'b1;
        else              o_bmask = 4'b0011 << i_addr_lo;
      end
      default: begin
        if (i_addr_lo != 2'b00) o_misaligned = 1'b1;
        else                    o_bmask = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/lsu_store_buffer.sv
// LSU store side: decodes the store address, updates the I/O output-buffer registers
// or drives a data-memory write, and times the LCD write strobe/busy window.
module lsu_store_buffer
  import lsu_pkg::*;
#(
  parameter int LCD_HOLD_CYCLES = 40
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_lsu_addr,
  input  logic        i_lsu_wren,
  input  logic [1:0]  i_st_size,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [55:0] o_io_hex,
  output logic [31:0] o_io_lcd,
  output logic        o_lcd_wr,
  output logic        o_lcd_busy,
  output logic [31:0] o_op_bf_rdata,
  output logic        o_mem_wren,
  output logic [3:0]  o_mem_bmask,
  output logic [31:0] o_mem_wdata,
  output logic        o_st_misaligned
);

  localparam int CNT_W = $clog2(LCD_HOLD_CYCLES + 1);

  logic [31:0]      r_ledr, r_ledg, r_lcd;
  logic [7:0][6:0]  r_hex;
  logic [CNT_W-1:0] r_lcd_cnt;
  logic             r_lcd_wr, r_st_misaligned;

  region_e     w_region;
  logic [1:0]  w_word;
  logic [3:0]  w_bmask;
  logic [31:0] w_wdata;
  logic        w_misaligned, w_st_ok;
  logic        w_wr_ledr, w_wr_ledg, w_wr_hex, w_wr_lcd;

  lsu_st_align u_align (
    .i_st_size   (i_st_size),
    .i_addr_lo   (i_lsu_addr[1:0]),
    .i_st_data   (i_st_data),
    .o_bmask     (w_bmask),
    .o_wdata     (w_wdata),
    .o_misaligned(w_misaligned)
  );

  assign w_region  = decode_region(i_lsu_addr[15:4]);
  assign w_word    = i_lsu_addr[3:2];
  assign w_st_ok   = i_lsu_wren & ~w_misaligned & ~i_reset;
  assign w_wr_ledr = w_st_ok & (w_region == RG_LEDR) & (w_word == 2'd0);
  assign w_wr_ledg = w_st_ok & (w_region == RG_LEDG) & (w_word == 2'd0);
  assign w_wr_lcd  = w_st_ok & (w_region == RG_LCD)  & (w_word == 2'd0);
  assign w_wr_hex  = w_st_ok & (w_region == RG_HEX)  & ~w_word[1];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ledr          <= '0;
      r_ledg          <= '0;
      r_lcd           <= '0;
      r_hex           <= '0;
      r_lcd_cnt       <= '0;
      r_lcd_wr        <= 1'b0;
      r_st_misaligned <= 1'b0;
    end else begin
      if (i_lsu_wren) r_st_misaligned <= w_misaligned;
      r_lcd_wr <= w_wr_lcd;
      // A write while busy restarts the full hold window.
      if (w_wr_lcd)              r_lcd_cnt <= CNT_W'(LCD_HOLD_CYCLES);
      else if (r_lcd_cnt != '0)  r_lcd_cnt <= r_lcd_cnt - CNT_W'(1);
      for (int j = 0; j < 4; j++) begin
        if (w_bmask[j]) begin
          if (w_wr_ledr) r_ledr[8*j +: 8] <= w_wdata[8*j +: 8];
          if (w_wr_ledg) r_ledg[8*j +: 8] <= w_wdata[8*j +: 8];
          if (w_wr_lcd)  r_lcd[8*j +: 8]  <= w_wdata[8*j +: 8];
          if (w_wr_hex)  r_hex[{w_word[0], 2'(j)}] <= w_wdata[8*j +: 7];
        end
      end
    end
  end

  always_comb begin
    o_op_bf_rdata = '0;
    case (w_region)
      RG_LEDR: if (w_word == 2'd0) o_op_bf_rdata = r_ledr;
      RG_LEDG: if (w_word == 2'd0) o_op_bf_rdata = r_ledg;
      RG_LCD:  if (w_word == 2'd0) o_op_bf_rdata = r_lcd;
      RG_HEX: begin
        if (!w_word[1]) begin
          for (int j = 0; j < 4; j++)
            o_op_bf_rdata[8*j +: 8] = {1'b0, r_hex[{w_word[0], 2'(j)}]};
        end
      end
      default: o_op_bf_rdata = '0;
    endcase
  end

  assign o_io_ledr       = r_ledr;
  assign o_io_ledg       = r_ledg;
  assign o_io_lcd        = r_lcd;
  assign o_io_hex        = r_hex;
  assign o_lcd_wr        = r_lcd_wr;
  assign o_lcd_busy      = (r_lcd_cnt != '0);
  assign o_st_misaligned = r_st_misaligned;
  assign o_mem_wren      = w_st_ok & (w_region == RG_MEM);
  assign o_mem_bmask     = w_bmask;
  assign o_mem_wdata     = w_wdata;

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Bench for lsu_store_buffer: directed board scenarios, then random stores checked
// against a byte-level model of the I/O buffer.
module tb_lsu_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        wren;
  logic [1:0]  size;
  logic [31:0] data;
  logic [31:0] ledr, ledg, lcd, rdata, mwdata;
  logic [55:0] hex;
  logic        lcd_wr, lcd_busy, mwren, mis;
  logic [3:0]  mmask;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  m_ledr [4];
  logic [7:0]  m_ledg [4];
  logic [7:0]  m_lcd  [4];
  logic [6:0]  m_hex  [8];
  logic        m_mis;
  logic [31:0] exp_q [$];

  lsu_store_buffer #(.LCD_HOLD_CYCLES(40)) dut (
    .i_clk(clk), .i_reset(rst), .i_lsu_addr(addr), .i_lsu_wren(wren),
    .i_st_size(size), .i_st_data(data), .o_io_ledr(ledr), .o_io_ledg(ledg),
    .o_io_hex(hex), .o_io_lcd(lcd), .o_lcd_wr(lcd_wr), .o_lcd_busy(lcd_busy),
    .o_op_bf_rdata(rdata), .o_mem_wren(mwren), .o_mem_bmask(mmask),
    .o_mem_wdata(mwdata), .o_st_misaligned(mis)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int n_bytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  // 0 mem, 1 ledr, 2 ledg, 3 hex, 4 lcd, 5 switches
  function automatic int region_of(input logic [15:0] a);
    int page = int'(a) / 16;
    if (page >= 'h700 && page <= 'h703) return page - 'h700 + 1;
    if (page == 'h780) return 5;
    return 0;
  endfunction

  function automatic logic [31:0] pack4(input logic [7:0] b [4]);
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic logic [55:0] exp_hex();
    logic [55:0] v = '0;
    for (int k = 0; k < 8; k++) v[7*k +: 7] = m_hex[k];
    return v;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [15:0] a);
    int wd = (int'(a) / 4) % 4;
    logic [31:0] v = '0;
    case (region_of(a))
      1: if (wd == 0) v = pack4(m_ledr);
      2: if (wd == 0) v = pack4(m_ledg);
      4: if (wd == 0) v = pack4(m_lcd);
      3: if (wd < 2) for (int l = 0; l < 4; l++) v[8*l +: 8] = {1'b0, m_hex[wd*4 + l]};
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_ledr[i] = 0; m_ledg[i] = 0; m_lcd[i] = 0; end
    for (int i = 0; i < 8; i++) m_hex[i] = 0;
    m_mis = 0;
  endtask

  task automatic model_store(input logic [15:0] a, input logic [1:0] s, input logic [31:0] d);
    int n = n_bytes(s);
    if (int'(a) % n != 0) begin m_mis = 1; return; end
    m_mis = 0;
    for (int k = 0; k < n; k++) begin
      int b = int'(a) + k;
      int lane = b % 4;
      int wd = (b / 4) % 4;
      logic [7:0] v = d[8*k +: 8];
      case (region_of(a))
        1: if (wd == 0) m_ledr[lane] = v;
        2: if (wd == 0) m_ledg[lane] = v;
        4: if (wd == 0) m_lcd[lane] = v;
        3: if (wd < 2) m_hex[wd*4 + lane] = v[6:0];
        default: ;
      endcase
    end
  endtask

  task automatic check_regs(input string tag, input logic [15:0] rd_addr);
    chk({tag, ".ledr"}, 64'(ledr), 64'(pack4(m_ledr)));
    chk({tag, ".ledg"}, 64'(ledg), 64'(pack4(m_ledg)));
    chk({tag, ".lcd"},  64'(lcd),  64'(pack4(m_lcd)));
    chk({tag, ".hex"},  64'(hex),  64'(exp_hex()));
    chk({tag, ".mis"},  64'(mis),  64'(m_mis));
    addr = rd_addr;
    exp_q.push_back(exp_rd(rd_addr));
    #1;
    chk({tag, ".rdata"}, 64'(rdata), 64'(exp_q.pop_front()));
  endtask

  // Drives one store for one clock edge, checks the memory port before the edge and
  // every buffer register plus readback of the same address after it.
  task automatic do_store(input string tag, input logic [15:0] a, input logic [1:0] s,
                          input logic [31:0] d);
    int n = n_bytes(s);
    bit aligned = (int'(a) % n == 0);
    logic [3:0] e_mask = '0;
    logic [31:0] e_wd;
    for (int k = 0; k < n; k++) e_mask[(int'(a) % 4) + k] = 1'b1;
    for (int l = 0; l < 4; l++) e_wd[8*l +: 8] = d[8*(l % n) +: 8];
    addr = a; size = s; data = d; wren = 1'b1;
    #1;
    chk({tag, ".mwren"}, 64'(mwren), 64'(aligned && region_of(a) == 0));
    if (aligned) begin
      chk({tag, ".bmask"}, 64'(mmask), 64'(e_mask));
      chk({tag, ".wdata"}, 64'(mwdata), 64'(e_wd));
    end
    @(posedge clk);
    model_store(a, s, d);
    @(negedge clk);
    wren = 1'b0;
    check_regs(tag, a);
  endtask

  task automatic count_lcd(input int ncyc, output int busy_n, output int wr_n);
    busy_n = 0; wr_n = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (lcd_busy) busy_n++;
      if (lcd_wr) wr_n++;
      @(negedge clk); #1;
    end
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1; wren = 1'b1; addr = 16'h0100; size = 2'd2; data = 32'hFFFF_FFFF;
    #1;
    chk({tag, ".mwren_in_reset"}, 64'(mwren), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; wren = 1'b0;
    model_reset();
    #1;
    chk({tag, ".busy"}, 64'(lcd_busy), 64'd0);
    chk({tag, ".lcd_wr"}, 64'(lcd_wr), 64'd0);
    check_regs(tag, 16'h7000);
  endtask

  initial begin
    int b, w;
    logic [15:0] bases [6];
    rst = 1'b1; wren = 1'b0; addr = '0; size = '0; data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    apply_reset("reset");

    do_store("sw_ledr", 16'h7000, 2'd2, 32'hA5A5_1234);
    chk("ledr_literal", 64'(ledr), 64'h0000_0000_A5A5_1234);
    chk("ledr_readback", 64'(rdata), 64'h0000_0000_A5A5_1234);

    do_store("sw_hex1", 16'h7024, 2'd2, 32'h0102_0304);
    do_store("sb_hex", 16'h7026, 2'd0, 32'h0000_007F);
    chk("hex_digit6", 64'(hex[48:42]), 64'h7F);
    chk("hex_digit7", 64'(hex[55:49]), 64'h01);

    do_store("sh_mem", 16'h0102, 2'd1, 32'h0000_BEEF);
    chk("sh_mem_wdata", 64'(mwdata), 64'h0000_0000_BEEF_BEEF);
    do_store("sh_mis", 16'h0101, 2'd1, 32'h0000_1111);
    chk("mis_set", 64'(mis), 64'd1);
    do_store("sw_sw", 16'h7800, 2'd2, 32'hDEAD_BEEF);
    chk("mis_clear", 64'(mis), 64'd0);
    do_store("sw_ledr_w1", 16'h7004, 2'd2, 32'h1357_9BDF);
    do_store("sw_word3", 16'h7010, 2'd3, 32'h0F0F_F0F0);

    do_store("lcd1", 16'h7030, 2'd2, 32'h0000_0041);
    chk("lcd1_wr", 64'(lcd_wr), 64'd1);
    count_lcd(60, b, w);
    chk("lcd1_busy_cycles", 64'(b), 64'd40);
    chk("lcd1_strobes", 64'(w), 64'd1);

    do_store("lcd2", 16'h7030, 2'd2, 32'h0000_0042);
    count_lcd(20, b, w);
    chk("lcd2_busy_pre", 64'(b), 64'd20);
    chk("lcd2_strobes_pre", 64'(w), 64'd1);
    do_store("lcd3", 16'h7030, 2'd0, 32'h0000_0043);
    count_lcd(60, b, w);
    chk("lcd3_busy_after", 64'(b), 64'd40);
    chk("lcd3_strobes", 64'(w), 64'd1);

    do_store("lcd4", 16'h7030, 2'd2, 32'h0000_0044);
    do_store("mis_pre_rst", 16'h7001, 2'd1, 32'h0000_5555);
    count_lcd(8, b, w);
    chk("pre_rst_busy", 64'(lcd_busy), 64'd1);
    apply_reset("mid_hold_reset");

    bases[0] = 16'h7000; bases[1] = 16'h7010; bases[2] = 16'h7020;
    bases[3] = 16'h7030; bases[4] = 16'h7800; bases[5] = 16'h0000;
    for (int i = 0; i < 200; i++) begin
      int r = $urandom_range(0, 5);
      logic [15:0] a = (r == 5) ? 16'($urandom_range(0, 'h6FFF))
                                : bases[r] + 16'($urandom_range(0, 15));
      do_store("rand", a, 2'($urandom_range(0, 3)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
